// File: rtl/rv32_main_fsm.sv
// Multicycle control FSM for the RV32 core: sequences fetch/decode/execute/memory/writeback
// and drives the datapath mux selects and architectural write enables.
module rv32_main_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] alu_op,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALR_PC, S_LUI, S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Registered Moore outputs plus flags for the enables that are qualified by live inputs.
  typedef struct packed {
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_write;
    logic       illegal;
    logic       fetch;
    logic       branch;
    logic       pc_force;
  } ctl_t;

  state_t state;
  state_t state_nxt;
  ctl_t   ctl;
  ctl_t   fetch_ctl;
  ctl_t   cur;

  function automatic state_t next_state(input state_t s, input logic [6:0] opc,
                                        input logic [2:0] f3, input logic rdy);
    case (s)
      S_FETCH:    return rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opc)
          OP_LOAD, OP_STORE: return S_MEMADR;
          OP_R:              return S_EXECR;
          OP_I:              return S_EXECI;
          OP_BRANCH:         return (f3[2:1] == 2'b00) ? S_BRANCH : S_TRAP;
          OP_JAL:            return S_JAL;
          OP_JALR:           return S_JALR;
          OP_LUI:            return S_LUI;
          default:           return S_TRAP;
        endcase
      end
      S_MEMADR:   return (opc == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  return rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: return rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL, S_JALR_PC, S_LUI: return S_ALUWB;
      S_JALR:     return S_JALR_PC;
      S_TRAP:     return S_TRAP;
      default:    return S_FETCH;
    endcase
  endfunction

  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    // NOTE: default every field first so no path leaves a value unassigned (no latch, no X).
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b10; c.result_src = 2'b10; c.fetch = 1'b1;
      end
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD:  c.adr_src = 1'b1;
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    c.reg_write = 1'b1;
      S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JAL, S_JALR_PC: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_force = 1'b1;
      end
      S_JALR:     begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_LUI:      begin c.alu_src_a = 2'b11; c.alu_src_b = 2'b01; end
      S_TRAP:     c.illegal = 1'b1;
      default:    c = '0;
    endcase
    return c;
  endfunction

  assign state_nxt = next_state(state, op, funct3, mem_ready);
  assign fetch_ctl = decode_ctl(S_FETCH);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
      ctl   <= fetch_ctl;
    end else begin
      state <= state_nxt;
      ctl   <= decode_ctl(state_nxt);
    end
  end

  // While reset is asserted, selects show FETCH and every enable is held off, even before the edge.
  always_comb begin
    cur           = rst_n ? ctl : fetch_ctl;
    adr_src       = cur.adr_src;
    alu_src_a     = cur.alu_src_a;
    alu_src_b     = cur.alu_src_b;
    result_src    = cur.result_src;
    alu_op        = cur.alu_op;
    ir_write      = rst_n & cur.fetch & mem_ready;
    pc_write      = rst_n & (cur.pc_force | (cur.fetch & mem_ready) |
                             (cur.branch & (zero ^ funct3[0])));
    mem_write     = rst_n & cur.mem_write;
    reg_write     = rst_n & cur.reg_write;
    illegal_instr = rst_n & cur.illegal;
  end

endmodule

// File: tb/tb_rv32_main_fsm.sv
// Directed self-checking bench for rv32_main_fsm: per-cycle output vectors against hand-built
// expectations for each instruction class, wait states, branches, trap and reset.
module tb_rv32_main_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [13:0] obs;

  int total = 0;
  int bad   = 0;

  rv32_main_fsm dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_op(alu_op), .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // {pc_write, adr_src, ir_write, mem_write, reg_write, a, b, result_src, alu_op, illegal}
  assign obs = {pc_write, adr_src, ir_write, mem_write, reg_write,
                alu_src_a, alu_src_b, result_src, alu_op, illegal_instr};

  localparam logic [13:0] W_FETCH_R = 14'b1_0_1_0_0_00_10_10_00_0;
  localparam logic [13:0] W_FETCH_W = 14'b0_0_0_0_0_00_10_10_00_0;
  localparam logic [13:0] W_RST     = 14'b0_0_0_0_0_00_10_10_00_0;
  localparam logic [13:0] W_DECODE  = 14'b0_0_0_0_0_01_01_00_00_0;
  localparam logic [13:0] W_MEMADR  = 14'b0_0_0_0_0_10_01_00_00_0;
  localparam logic [13:0] W_MEMREAD = 14'b0_1_0_0_0_00_00_00_00_0;
  localparam logic [13:0] W_MEMWB   = 14'b0_0_0_0_1_00_00_01_00_0;
  localparam logic [13:0] W_MEMWR   = 14'b0_1_0_1_0_00_00_00_00_0;
  localparam logic [13:0] W_EXECR   = 14'b0_0_0_0_0_10_00_00_10_0;
  localparam logic [13:0] W_EXECI   = 14'b0_0_0_0_0_10_01_00_10_0;
  localparam logic [13:0] W_ALUWB   = 14'b0_0_0_0_1_00_00_00_00_0;
  localparam logic [13:0] W_BR_T    = 14'b1_0_0_0_0_10_00_00_01_0;
  localparam logic [13:0] W_BR_N    = 14'b0_0_0_0_0_10_00_00_01_0;
  localparam logic [13:0] W_JAL     = 14'b1_0_0_0_0_01_10_00_00_0;
  localparam logic [13:0] W_JALR    = 14'b0_0_0_0_0_10_01_00_00_0;
  localparam logic [13:0] W_JALR_PC = 14'b1_0_0_0_0_01_10_00_00_0;
  localparam logic [13:0] W_LUI     = 14'b0_0_0_0_0_11_01_00_00_0;
  localparam logic [13:0] W_TRAP    = 14'b0_0_0_0_0_00_00_00_00_1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = 7'b0110011; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (obs !== W_RST) begin
        bad++;
        $display("FAIL reset cycle %0d: got %b expected %b", i, obs, W_RST);
      end
      tick();
    end
    rst_n = 1'b1; mem_ready = 1'b0;
    #1;
    total++;
    if (obs !== W_FETCH_W) begin
      bad++;
      $display("FAIL reset_release: got %b expected %b", obs, W_FETCH_W);
    end
    tick();
  endtask

  task automatic test_load();
    logic        mr_v  [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [13:0] exp_v [7] = '{W_FETCH_W, W_FETCH_R, W_DECODE, W_MEMADR, W_MEMREAD,
                               W_MEMREAD, W_MEMWB};
    op = 7'b0000011; funct3 = 3'b010;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr_v[i];
      #1;
      total++;
      if (obs !== exp_v[i]) begin
        bad++;
        $display("FAIL lw cycle %0d: got %b expected %b", i, obs, exp_v[i]);
      end
      tick();
    end
    mem_ready = 1'b0;
    #1;
    total++;
    if (obs !== W_FETCH_W) begin
      bad++;
      $display("FAIL lw_return: got %b expected %b", obs, W_FETCH_W);
    end
    tick();
  endtask

  task automatic test_store();
    logic        mr_v  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [13:0] exp_v [7] = '{W_FETCH_R, W_DECODE, W_MEMADR, W_MEMWR, W_MEMWR, W_MEMWR,
                               W_FETCH_W};
    op = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr_v[i];
      #1;
      total++;
      if (obs !== exp_v[i]) begin
        bad++;
        $display("FAIL sw cycle %0d: got %b expected %b", i, obs, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_alu_ops();
    logic [6:0]  ops  [4] = '{7'b0110011, 7'b0010011, 7'b1101111, 7'b0110111};
    logic [13:0] mids [4] = '{W_EXECR, W_EXECI, W_JAL, W_LUI};
    logic [13:0] e;
    for (int k = 0; k < 4; k++) begin
      op = ops[k]; funct3 = 3'b000;
      for (int i = 0; i < 5; i++) begin
        mem_ready = (i < 4);
        case (i)
          0:       e = W_FETCH_R;
          1:       e = W_DECODE;
          2:       e = mids[k];
          3:       e = W_ALUWB;
          default: e = W_FETCH_W;
        endcase
        #1;
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL alu_op %0d cycle %0d: got %b expected %b", k, i, obs, e);
        end
        tick();
      end
    end
  endtask

  task automatic test_branch();
    logic [2:0]  f3_v [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
    logic        z_v  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [13:0] br_v [4] = '{W_BR_T, W_BR_N, W_BR_T, W_BR_N};
    logic [13:0] e;
    op = 7'b1100011;
    for (int k = 0; k < 4; k++) begin
      funct3 = f3_v[k]; zero = z_v[k];
      for (int i = 0; i < 4; i++) begin
        mem_ready = (i < 3);
        case (i)
          0:       e = W_FETCH_R;
          1:       e = W_DECODE;
          2:       e = br_v[k];
          default: e = W_FETCH_W;
        endcase
        #1;
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL branch %0d cycle %0d: got %b expected %b", k, i, obs, e);
        end
        tick();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jalr();
    logic [13:0] exp_v [6] = '{W_FETCH_R, W_DECODE, W_JALR, W_JALR_PC, W_ALUWB, W_FETCH_W};
    op = 7'b1100111; funct3 = 3'b000;
    for (int i = 0; i < 6; i++) begin
      mem_ready = (i < 5);
      #1;
      total++;
      if (obs !== exp_v[i]) begin
        bad++;
        $display("FAIL jalr cycle %0d: got %b expected %b", i, obs, exp_v[i]);
      end
      tick();
    end
  endtask

  task automatic test_trap();
    logic [13:0] e;
    op = 7'b1111111; funct3 = 3'b001; zero = 1'b1;
    for (int i = 0; i < 14; i++) begin
      rst_n     = (i != 12);
      mem_ready = (i < 2) ? 1'b1 : ((i == 13) ? 1'b0 : 1'(i % 2));
      if (i == 0)       e = W_FETCH_R;
      else if (i == 1)  e = W_DECODE;
      else if (i < 12)  e = W_TRAP;
      else if (i == 12) e = W_RST;
      else              e = W_FETCH_W;
      #1;
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL trap cycle %0d: got %b expected %b", i, obs, e);
      end
      tick();
    end
    // Unsupported branch funct3 must also trap.
    op = 7'b1100011; funct3 = 3'b010; zero = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rst_n     = (i != 3);
      mem_ready = (i < 2) || (i == 3);
      case (i)
        0:       e = W_FETCH_R;
        1:       e = W_DECODE;
        2:       e = W_TRAP;
        3:       e = W_RST;
        default: e = W_FETCH_W;
      endcase
      #1;
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL branch_trap cycle %0d: got %b expected %b", i, obs, e);
      end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_write();
    logic        rst_v [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        mr_v  [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [13:0] exp_v [6] = '{W_FETCH_R, W_DECODE, W_MEMADR, W_MEMWR, W_RST, W_FETCH_W};
    op = 7'b0100011; funct3 = 3'b010;
    for (int i = 0; i < 6; i++) begin
      rst_n = rst_v[i]; mem_ready = mr_v[i];
      #1;
      total++;
      if (obs !== exp_v[i]) begin
        bad++;
        $display("FAIL sw_reset cycle %0d: got %b expected %b", i, obs, exp_v[i]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_alu_ops();
    test_branch();
    test_jalr();
    test_trap();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32_main_fsm.md
# rv32_main_fsm

Multicycle control state machine for the RV32 core. Decodes the instruction register opcode, sequences each instruction through fetch/decode/execute/memory/writeback, and drives the select inputs of the datapath's 4:1 operand and result multiplexers plus all architectural write enables. It sits directly upstream of those muxes, register file, PC, IR and memory port, and has a single-bit ready handshake to memory.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  synchronous, active-low reset
- op  in  7  instr[6:0] from the IR
- funct3  in  3  instr[14:12]
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  IR and OldPC load enable
- mem_write  out  1  memory write request
- reg_write  out  1  register file write enable
- alu_src_a  out  2  A mux select: 00 PC, 01 OldPC, 10 rs1 register, 11 constant 0
- alu_src_b  out  2  B mux select: 00 rs2 register, 01 ImmExt, 10 constant 4, 11 unused
- result_src  out  2  result mux select: 00 ALUOut, 01 Data register, 10 ALUResult, 11 unused
- alu_op  out  2  00 add, 01 subtract, 10 decode from funct3/funct7
- illegal_instr  out  1  sticky trap indicator

## Operation
- Moore machine: outputs are a pure function of state, except pc_write (uses zero, mem_ready, funct3) and ir_write/mem_write qualified as below. Unlisted outputs in a state are 0 / 00.
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10; ir_write=pc_write=mem_ready. mem_ready ? DECODE : FETCH.
- DECODE: a=01, b=01, alu_op=00 (branch/JAL target into ALUOut). Next by op: 0000011/0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 1100011→BRANCH if funct3∈{000,001}, else TRAP; 1101111→JAL; 1100111→JALR; 0110111→LUI; any other op→TRAP.
- MEMADR: a=10, b=01, alu_op=00. op=0000011 → MEMREAD, else MEMWRITE.
- MEMREAD: adr_src=1. mem_ready ? MEMWB : MEMREAD.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: adr_src=1, mem_write=1 (held until accepted). mem_ready ? FETCH : MEMWRITE.
- EXECR: a=10, b=00, alu_op=10 → ALUWB. EXECI: a=10, b=01, alu_op=10 → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00; pc_write = zero XOR funct3[0] (beq/bne). → FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1 → ALUWB (writes OldPC+4 to rd).
- JALR: a=10, b=01, alu_op=00 → JALR_PC. JALR_PC: result_src=00, pc_write=1, a=01, b=10, alu_op=00 → ALUWB.
- LUI: a=11, b=01, alu_op=00 → ALUWB.
- TRAP: all enables 0, illegal_instr=1; stays in TRAP until reset.

## Timing
- Reset: rst_n sampled low at an edge → state=FETCH. While rst_n is low, pc_write, ir_write, mem_write and reg_write are forced 0 and illegal_instr=0. Selects take FETCH values.
- Reset mid-instruction, including MEMWRITE with mem_ready=0: abort at that edge, with no further write enable. The first cycle with rst_n high is FETCH.
- Cycle counts with mem_ready=1: lw 5, sw 4, R/I-ALU 4, branch 3, jal 4, jalr 5, lui 4. Each wait cycle on mem_ready adds 1 cycle in FETCH/MEMREAD/MEMWRITE.
- Exactly one pc_write pulse per FETCH completion. At most one more pulse per instruction (branch taken, JAL, JALR_PC).
- Next-state decode in DECODE uses op/funct3 as they stand in that cycle. The IR is stable there.

## Test plan
- Reset: hold rst_n=0 three cycles while op=0110011 → all enables 0; first cycle after release is FETCH, with a=00, b=10, result_src=10.
- lw, op=0000011, mem_ready=1 → states FETCH, DECODE, MEMADR, MEMREAD, MEMWB over 5 cycles; reg_write=1 only in cycle 5 with result_src=01.
- sw with mem_ready low for 2 cycles in MEMWRITE → mem_write=1 for 3 consecutive cycles, then FETCH.
- Branch, op=1100011: funct3=000, zero=1 → pc_write=1 in cycle 3. Same with zero=0 → pc_write=0. funct3=001, zero=0 → pc_write=1.
- jalr: pc_write pulses in FETCH and JALR_PC only; reg_write in ALUWB with result_src=00 and a=01/b=10 the cycle before.
- op=1111111 → TRAP after DECODE; illegal_instr=1 and no enables for 10 cycles. rst_n=0 clears it and returns to FETCH.
